// File: rtl/ledtest_switch_debounce.sv
// Two-flop synchroniser and per-bit debouncer for the board slide switches, with registered rise/fall strobes.
// Define SWITCH_DEBOUNCE_IRQ_EN to add sticky edge capture (edge_capture, irq_clear) and a registered irq output.
module ledtest_switch_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
`ifdef SWITCH_DEBOUNCE_IRQ_EN
  input  logic [WIDTH-1:0] irq_clear,
  output logic [WIDTH-1:0] edge_capture,
  output logic             irq,
`endif
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [WIDTH-1:0]     sync1;
  logic [WIDTH-1:0]     sync2;
  state_t               state_q [WIDTH];
  state_t               state_d [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_q   [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_d   [WIDTH];
  logic [WIDTH-1:0]     clean_d;
  logic [WIDTH-1:0]     rise_d;
  logic [WIDTH-1:0]     fall_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // Any return of sync2 to the accepted level restarts the whole window.
  always_comb begin
    clean_d = sw_clean;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (sync2[i] == sw_clean[i]) begin
        state_d[i] = STABLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          STABLE: begin
            state_d[i] = COUNTING;
            cnt_d[i]   = CNT_ONE;
          end
          COUNTING: begin
            if (cnt_q[i] == CNT_MAX) begin
              state_d[i] = STABLE;
              cnt_d[i]   = '0;
              clean_d[i] = sync2[i];
              rise_d[i]  = sync2[i];
              fall_d[i]  = ~sync2[i];
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end
          default: begin
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
      sw_clean   <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      sw_clean   <= clean_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
    end
  end

`ifdef SWITCH_DEBOUNCE_IRQ_EN
  // A strobe arriving with its clear wins, so no edge is ever lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
      irq          <= 1'b0;
    end else begin
      edge_capture <= (edge_capture & ~irq_clear) | rise_pulse | fall_pulse;
      irq          <= |edge_capture;
    end
  end
`endif

endmodule

// File: tb/tb_ledtest_switch_debounce.sv
// Directed bench for ledtest_switch_debounce with DEBOUNCE_CYCLES=8, so accepted changes land 10 edges after sampling.
// The edge-capture checks are compiled only when SWITCH_DEBOUNCE_IRQ_EN is defined.
module tb_ledtest_switch_debounce;

  localparam int WIDTH = 4;
  localparam int DEB   = 8;
  localparam int CNTW  = 20;

  typedef struct {
    logic       rst_n;
    logic [3:0] sw;
    logic [3:0] clean;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic [3:0] sw_raw;
  logic [3:0] sw_clean;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
`ifdef SWITCH_DEBOUNCE_IRQ_EN
  logic [3:0] irq_clear;
  logic [3:0] edge_capture;
  logic       irq;
`endif

  int compared   = 0;
  int mismatched = 0;
  vec_t vecs[$];

  ledtest_switch_debounce #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sw_raw(sw_raw),
`ifdef SWITCH_DEBOUNCE_IRQ_EN
    .irq_clear(irq_clear),
    .edge_capture(edge_capture),
    .irq(irq),
`endif
    .sw_clean(sw_clean),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic add_rows(input logic r, input logic [3:0] s, input int n,
                          input logic [3:0] c, input logic [3:0] ri, input logic [3:0] fa);
    vec_t v;
    v.rst_n = r;
    v.sw    = s;
    v.clean = c;
    v.rise  = ri;
    v.fall  = fa;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] s);
    reset_n = r;
    sw_raw  = s;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] c, input logic [3:0] ri, input logic [3:0] fa);
    checkOutput({tag, " sw_clean"}, sw_clean, c);
    checkOutput({tag, " rise_pulse"}, rise_pulse, ri);
    checkOutput({tag, " fall_pulse"}, fall_pulse, fa);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds sw for 11 edges: unchanged for 9, new level plus strobe on the 10th, strobe gone on the 11th.
  task automatic settle(input string tag, input logic [3:0] s, input logic [3:0] old_c,
                        input logic [3:0] new_c, input logic [3:0] ri, input logic [3:0] fa);
    sw_raw = s;
    for (int k = 1; k <= 9; k++) begin
      step();
      check_all($sformatf("%s e%0d", tag, k), old_c, 4'h0, 4'h0);
    end
    step();
    check_all({tag, " e10"}, new_c, ri, fa);
    step();
    check_all({tag, " e11"}, new_c, 4'h0, 4'h0);
  endtask

  initial begin
    // Reset with all switches high, release, then a simultaneous fall on bits 1 and 3,
    // a fall of the rest, and a clean single-bit rise on bit 0.
    add_rows(1'b0, 4'hF, 2, 4'h0, 4'h0, 4'h0);
    add_rows(1'b1, 4'hF, 9, 4'h0, 4'h0, 4'h0);
    add_rows(1'b1, 4'hF, 1, 4'hF, 4'hF, 4'h0);
    add_rows(1'b1, 4'hF, 2, 4'hF, 4'h0, 4'h0);
    add_rows(1'b1, 4'h5, 9, 4'hF, 4'h0, 4'h0);
    add_rows(1'b1, 4'h5, 1, 4'h5, 4'h0, 4'hA);
    add_rows(1'b1, 4'h5, 2, 4'h5, 4'h0, 4'h0);
    add_rows(1'b1, 4'h0, 9, 4'h5, 4'h0, 4'h0);
    add_rows(1'b1, 4'h0, 1, 4'h0, 4'h0, 4'h5);
    add_rows(1'b1, 4'h0, 2, 4'h0, 4'h0, 4'h0);
    add_rows(1'b1, 4'h1, 9, 4'h0, 4'h0, 4'h0);
    add_rows(1'b1, 4'h1, 1, 4'h1, 4'h1, 4'h0);
    add_rows(1'b1, 4'h1, 2, 4'h1, 4'h0, 4'h0);

    reset_n = 1'b1;
    sw_raw  = 4'hF;
`ifdef SWITCH_DEBOUNCE_IRQ_EN
    irq_clear = 4'h0;
`endif
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async reset", 4'h0, 4'h0, 4'h0);
`ifdef SWITCH_DEBOUNCE_IRQ_EN
    checkOutput("async reset edge_capture", edge_capture, 4'h0);
    checkOutput("async reset irq", {3'b000, irq}, 4'h0);
`endif
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].sw);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].clean, vecs[i].rise, vecs[i].fall);
    end

    // Bit 2 toggles every 5 cycles for 40 cycles: always short of the window.
    for (int seg = 0; seg < 8; seg++) begin
      sw_raw = (seg % 2 == 0) ? 4'b0101 : 4'b0001;
      for (int k = 0; k < 5; k++) begin
        step();
        check_all($sformatf("bounce s%0d c%0d", seg, k), 4'b0001, 4'h0, 4'h0);
      end
    end
    settle("bounce hold", 4'b0101, 4'b0001, 4'b0101, 4'b0100, 4'h0);

    // Reset hit while bit 1 has counted 5; the window must restart in full afterwards.
    sw_raw = 4'b0111;
    for (int k = 1; k <= 7; k++) begin
      step();
      check_all($sformatf("midcount e%0d", k), 4'b0101, 4'h0, 4'h0);
    end
    reset_n = 1'b0;
    #1;
    check_all("midcount in reset", 4'h0, 4'h0, 4'h0);
    step();
    check_all("midcount reset edge", 4'h0, 4'h0, 4'h0);
    reset_n = 1'b1;
    settle("midcount release", 4'b0111, 4'h0, 4'b0111, 4'b0111, 4'h0);

`ifdef SWITCH_DEBOUNCE_IRQ_EN
    checkOutput("irq capture after release", edge_capture, 4'b0111);
    checkOutput("irq lags capture", {3'b000, irq}, 4'h0);
    irq_clear = 4'hF;
    step();
    checkOutput("irq clear all capture", edge_capture, 4'h0);
    checkOutput("irq clear all irq", {3'b000, irq}, 4'h1);
    irq_clear = 4'h0;
    step();
    checkOutput("irq drops", {3'b000, irq}, 4'h0);

    settle("irq fall0", 4'b0110, 4'b0111, 4'b0110, 4'h0, 4'b0001);
    irq_clear = 4'b0001;
    step();
    irq_clear = 4'h0;
    step();
    checkOutput("irq pre-rise capture", edge_capture, 4'h0);
    checkOutput("irq pre-rise irq", {3'b000, irq}, 4'h0);

    sw_raw = 4'b0111;
    repeat (10) step();
    check_all("irq rise0", 4'b0111, 4'b0001, 4'h0);
    step();
    checkOutput("irq rise capture", edge_capture, 4'b0001);
    checkOutput("irq rise irq not yet", {3'b000, irq}, 4'h0);
    step();
    checkOutput("irq rise irq", {3'b000, irq}, 4'h1);

    sw_raw = 4'b0110;
    repeat (10) step();
    check_all("irq fall0 again", 4'b0110, 4'h0, 4'b0001);
    irq_clear = 4'b0001;
    step();
    checkOutput("irq set beats clear", edge_capture, 4'b0001);
    irq_clear = 4'h0;
    step();
    checkOutput("irq held", {3'b000, irq}, 4'h1);
    irq_clear = 4'b0001;
    step();
    checkOutput("irq clear alone capture", edge_capture, 4'h0);
    irq_clear = 4'h0;
    step();
    checkOutput("irq clear alone irq", {3'b000, irq}, 4'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ledtest_switch_debounce.md
Name: ledtest_switch_debounce

Overview:
- Conditioning stage placed directly upstream of the Avalon switch-array input port.
- Synchronises the raw board slide switches into `clk`, then debounces each bit independently.
- Drives the clean bus into the PIO `in_port`.
- Also emits single-cycle rise and fall strobes per bit for use by other fabric logic.

Parameters:
- WIDTH, 4: number of switch bits.
- DEBOUNCE_CYCLES, 1000000: cycles a synchronised value must hold before acceptance (20 ms at 50 MHz). Legal range is 2 to 2^CNT_WIDTH-1.
- CNT_WIDTH, 20: width of each per-bit stability counter.

Ports:
- clk  in  1  system clock, single domain.
- reset_n  in  1  asynchronous, active-low reset.
- sw_raw  in  WIDTH  raw switch pins, asynchronous to clk.
- sw_clean  out  WIDTH  debounced level; feeds the switch-array in_port.
- rise_pulse  out  WIDTH  one-cycle strobe when sw_clean bit goes 0->1.
- fall_pulse  out  WIDTH  one-cycle strobe when sw_clean bit goes 1->0.

Behaviour:
- Interface: one clock, `clk`. Reset `reset_n` is asynchronous and active-low; all flops clear on its falling edge, independent of clk.
- Reset values: sync stages 0, counters 0, sw_clean 0, rise_pulse 0, fall_pulse 0.
- Synchroniser: two flops per bit (sync1 <= sw_raw, sync2 <= sync1). Only sync2 is used downstream.
- Per-bit state machine, one per bit with no shared state:
  - STABLE (sync2 == clean): counter held at 0.
  - COUNTING (sync2 != clean): counter increments by 1 each edge.
  - Any cycle where sync2 returns to equal clean clears the counter and returns to STABLE. Every bounce restarts the full window.
  - When counter == DEBOUNCE_CYCLES-1 and sync2 != clean on an edge: clean <= sync2, counter <= 0, and the matching rise/fall pulse register <= 1.
- Counter never exceeds DEBOUNCE_CYCLES-1, so no wrap is possible.
- Latency:
  - Edge 1 is the first rising edge that samples a new, thereafter-stable sw_raw.
  - sw_clean changes on edge DEBOUNCE_CYCLES+2.
  - The pulse is high for exactly the one cycle following that edge, coincident with the first cycle of the new sw_clean value.
- Pulses are registered outputs, high for exactly one cycle, and are 0 in every other cycle.
- rise and fall on the same bit are mutually exclusive.
- Different bits may pulse in the same cycle.
- Switch held high through reset release: sw_clean rises DEBOUNCE_CYCLES+2 edges after release, with a rise_pulse. This is intended; downstream logic treats it as a real edge.
- Reset asserted mid-count: counting is abandoned, clean stays/returns to 0, and after release the full window restarts.
- All arithmetic is unsigned CNT_WIDTH; comparisons use DEBOUNCE_CYCLES-1 truncated to CNT_WIDTH.

Optional Feature:
- Macro: SWITCH_DEBOUNCE_IRQ_EN.
- When defined:
  - Adds input `irq_clear` (WIDTH) and outputs `edge_capture` (WIDTH) and `irq` (1).
  - edge_capture[i] sets on rise_pulse[i] | fall_pulse[i] and clears on irq_clear[i].
  - A simultaneous set and clear leaves the bit set.
  - irq = |edge_capture, registered, so it appears one cycle after the capture bit.
  - Reset value of edge_capture and irq is 0.
- When undefined: these ports and registers do not exist, and the remaining behaviour is identical.

Test Plan:
- Reset: hold reset_n=0 with sw_raw=4'hF -> all outputs 0. Release with DEBOUNCE_CYCLES=8 -> sw_clean=4'hF and rise_pulse=4'hF for one cycle, starting exactly 10 edges after release.
- Clean step: DEBOUNCE_CYCLES=8, sw_raw[0] 0->1 and held -> sw_clean[0]=1 first visible after edge 10. rise_pulse[0]=1 only in that cycle. fall_pulse stays 0.
- Bounce: toggle sw_raw[2] every 5 cycles for 40 cycles, then hold 1 -> no change or pulse during the toggling. sw_clean[2] rises 10 edges after the last toggle is sampled.
- Simultaneous: sw_clean=4'hF, then drive sw_raw bits 1 and 3 low on the same edge -> fall_pulse=4'b1010 in one cycle. sw_clean=4'b0101.
- Reset mid-count: sw_raw[1]=1 held, pulse reset_n low at count 5 -> sw_clean[1] stays 0. It rises a full 10 edges after release.
- IRQ (macro defined): rise on bit0 -> edge_capture=4'b0001 and irq=1 one cycle later. irq_clear[0] asserted on the same cycle as a new fall_pulse[0] -> bit stays set. A later clear alone -> edge_capture=0 and irq=0.
